// File: rtl/sram_like_arbiter_pkg.sv
// Shared types and constants for the IF/EX SRAM-like port arbiter.
package sram_like_arbiter_pkg;

    localparam int SIZE_W = 2;
    localparam int STRB_W = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    localparam logic OWNER_INST = 1'b0;
    localparam logic OWNER_DATA = 1'b1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOCK_INST = 2'd1,
        LOCK_DATA = 2'd2
    } lock_state_e;

    typedef struct packed {
        logic              wr;
        logic [SIZE_W-1:0] size;
        logic [STRB_W-1:0] wstrb;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } sram_fields_t;

endpackage

// File: rtl/sram_like_arbiter_if.sv
// One SRAM-like channel: request fields from master, handshakes and read data from slave.
interface sram_like_arbiter_if;
    import sram_like_arbiter_pkg::*;

    logic              req;
    logic              wr;
    logic [SIZE_W-1:0] size;
    logic [STRB_W-1:0] wstrb;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              addr_ok;
    logic              data_ok;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );

endinterface

// File: rtl/sram_like_arbiter_req_owner_fifo.sv
// In-order FIFO of 1-bit owner tags for accepted, unanswered requests.
module req_owner_fifo #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic pop,
    input  logic din,
    output logic head,
    output logic empty,
    output logic full
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] mem_q, mem_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CW'(DEPTH));
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/sram_like_arbiter.sv
// Shares one SRAM-like port between IF and EX; data wins, grants lock until accepted.
module sram_like_arbiter
    import sram_like_arbiter_pkg::*;
#(
    parameter int OUTSTANDING = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    sram_like_arbiter_if.slave   inst_if,
    sram_like_arbiter_if.slave   data_if,
    sram_like_arbiter_if.master  sram_if
);
    lock_state_e  state_q, state_d;
    logic         gnt_vld, gnt_own;
    logic         sram_req, accept, pop;
    logic         fifo_full, fifo_empty, fifo_head;
    sram_fields_t inst_f, data_f, sel_f;

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // A full FIFO blocks new grants but never breaks an existing lock.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_own = OWNER_INST;
        unique case (state_q)
            IDLE: begin
                if (!fifo_full && data_if.req) begin
                    gnt_vld = 1'b1;
                    gnt_own = OWNER_DATA;
                end else if (!fifo_full && inst_if.req) begin
                    gnt_vld = 1'b1;
                end
            end
            LOCK_INST: gnt_vld = 1'b1;
            LOCK_DATA: begin
                gnt_vld = 1'b1;
                gnt_own = OWNER_DATA;
            end
            default: ;
        endcase
        if (reset) gnt_vld = 1'b0;
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = IDLE;
        end else if (gnt_vld) begin
            state_d = (gnt_own == OWNER_DATA) ? LOCK_DATA : LOCK_INST;
        end
    end

    assign sram_req = gnt_vld & ~fifo_full &
                      ((gnt_own == OWNER_DATA) ? data_if.req : inst_if.req);
    assign accept   = sram_req & sram_if.addr_ok;
    assign pop      = sram_if.data_ok & ~fifo_empty & ~reset;

    always_comb begin
        inst_f = {inst_if.wr, inst_if.size, inst_if.wstrb,
                  inst_if.addr, inst_if.wdata};
        data_f = {data_if.wr, data_if.size, data_if.wstrb,
                  data_if.addr, data_if.wdata};
        sel_f  = '0;
        if (gnt_vld) sel_f = (gnt_own == OWNER_DATA) ? data_f : inst_f;

        sram_if.req   = sram_req;
        sram_if.wr    = sel_f.wr;
        sram_if.size  = sel_f.size;
        sram_if.wstrb = sel_f.wstrb;
        sram_if.addr  = sel_f.addr;
        sram_if.wdata = sel_f.wdata;

        inst_if.addr_ok = accept & (gnt_own == OWNER_INST);
        data_if.addr_ok = accept & (gnt_own == OWNER_DATA);
        inst_if.data_ok = pop & (fifo_head == OWNER_INST);
        data_if.data_ok = pop & (fifo_head == OWNER_DATA);
        inst_if.rdata   = sram_if.rdata;
        data_if.rdata   = sram_if.rdata;
    end

    req_owner_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_owner_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (accept),
        .pop   (pop),
        .din   (gnt_own),
        .head  (fifo_head),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Scoreboard bench: requester/bridge models drive the arbiter, a monitor checks routing.
module tb_sram_like_arbiter;
    import sram_like_arbiter_pkg::*;

    localparam int OUTSTANDING = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sram_like_arbiter_if inst_bus ();
    sram_like_arbiter_if data_bus ();
    sram_like_arbiter_if sram_bus ();

    sram_like_arbiter #(
        .OUTSTANDING (OUTSTANDING)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .inst_if (inst_bus),
        .data_if (data_bus),
        .sram_if (sram_bus)
    );

    // stimulus intent for the next cycle
    logic        r_rst;
    logic        i_req;
    logic [31:0] i_addr, i_wdata;
    logic        d_req, d_wr;
    logic [1:0]  d_size;
    logic [3:0]  d_wstrb;
    logic [31:0] d_addr, d_wdata;
    logic        s_aok, s_dok;
    logic [31:0] s_rdata;

    // reference: owners of accepted-but-unanswered requests, oldest first
    bit sb_q[$];
    int lock_who;   // 0 none, 1 inst, 2 data
    int n_cmp = 0;
    int n_bad = 0;
    bit started = 1'b0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic step();
        int          gnt;
        logic        full, e_req, acc;
        logic [31:0] e_addr, e_wdata;
        logic [6:0]  e_ctl;
        @(posedge clk);
        #1;
        reset          = r_rst;
        inst_bus.req   = i_req;
        inst_bus.wr    = 1'b0;
        inst_bus.size  = 2'd2;
        inst_bus.wstrb = 4'h0;
        inst_bus.addr  = i_addr;
        inst_bus.wdata = i_wdata;
        data_bus.req   = d_req;
        data_bus.wr    = d_wr;
        data_bus.size  = d_size;
        data_bus.wstrb = d_wstrb;
        data_bus.addr  = d_addr;
        data_bus.wdata = d_wdata;
        sram_bus.addr_ok = s_aok;
        sram_bus.data_ok = s_dok;
        sram_bus.rdata   = s_rdata;
        started = 1'b1;
        #3;
        full = (sb_q.size() >= OUTSTANDING);
        if (r_rst)              gnt = 0;
        else if (lock_who != 0) gnt = lock_who;
        else if (!full && d_req) gnt = 2;
        else if (!full && i_req) gnt = 1;
        else                    gnt = 0;
        e_req = (gnt == 2) ? (d_req && !full) : (gnt == 1) ? (i_req && !full) : 1'b0;
        e_addr = 0; e_wdata = 0; e_ctl = 0;
        if (gnt == 2) begin
            e_addr = d_addr; e_wdata = d_wdata; e_ctl = {d_wr, d_size, d_wstrb};
        end else if (gnt == 1) begin
            e_addr = i_addr; e_wdata = i_wdata; e_ctl = {1'b0, 2'd2, 4'h0};
        end
        acc = e_req && s_aok;
        chk("sram_req", 32'(sram_bus.req), 32'(e_req));
        chk("sram_addr", sram_bus.addr, e_addr);
        chk("sram_wdata", sram_bus.wdata, e_wdata);
        chk("sram_ctl", 32'({sram_bus.wr, sram_bus.size, sram_bus.wstrb}), 32'(e_ctl));
        chk("inst_addr_ok", 32'(inst_bus.addr_ok), 32'(acc && gnt == 1));
        chk("data_addr_ok", 32'(data_bus.addr_ok), 32'(acc && gnt == 2));
        #4;
        if (r_rst) begin
            sb_q.delete();
            lock_who = 0;
            i_req = 1'b0;
            d_req = 1'b0;
        end else begin
            if (acc) sb_q.push_back(gnt == 2);
            lock_who = (gnt != 0 && !acc) ? gnt : 0;
            if (acc && gnt == 1) i_req = 1'b0;
            if (acc && gnt == 2) d_req = 1'b0;
        end
    endtask

    // Response monitor: routes every bridge data_ok against the owner queue.
    always @(negedge clk) begin
        bit o;
        if (started) begin
            if (!reset && sram_bus.data_ok && sb_q.size() > 0) begin
                o = sb_q.pop_front();
                chk("inst_data_ok", 32'(inst_bus.data_ok), 32'(!o));
                chk("data_data_ok", 32'(data_bus.data_ok), 32'(o));
                if (o) chk("data_rdata", data_bus.rdata, sram_bus.rdata);
                else   chk("inst_rdata", inst_bus.rdata, sram_bus.rdata);
            end else begin
                chk("idle_inst_data_ok", 32'(inst_bus.data_ok), 32'h0);
                chk("idle_data_data_ok", 32'(data_bus.data_ok), 32'h0);
            end
        end
    end

    task automatic quiet();
        i_req = 1'b0; d_req = 1'b0;
        s_aok = 1'b0; s_dok = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && sb_q.size() > 0; k++) begin
            quiet();
            s_dok   = 1'b1;
            s_rdata = $urandom;
            step();
        end
        s_dok = 1'b0;
        chk("drain_left", 32'(sb_q.size()), 32'h0);
    endtask

    task automatic new_data(input logic wr);
        d_req   = 1'b1;
        d_wr    = wr;
        d_size  = 2'($urandom);
        d_wstrb = 4'($urandom);
        d_addr  = $urandom;
        d_wdata = $urandom;
    endtask

    task automatic new_inst();
        i_req   = 1'b1;
        i_addr  = $urandom & 32'hFFFF_FFFC;
        i_wdata = $urandom;
    endtask

    initial begin
        lock_who = 0;
        r_rst = 1'b1;
        i_addr = 0; i_wdata = 0;
        d_wr = 0; d_size = 0; d_wstrb = 0; d_addr = 0; d_wdata = 0;
        s_rdata = 32'hDEAD_BEEF;
        quiet();
        // reset gating with live requests on every input
        new_inst(); new_data(1'b1); s_aok = 1'b1; s_dok = 1'b1;
        step();
        new_inst(); new_data(1'b0); s_aok = 1'b1; s_dok = 1'b1;
        step();
        r_rst = 1'b0;
        quiet();
        step();

        // simultaneous requests: data first, inst next cycle
        new_inst(); new_data(1'b0); s_aok = 1'b1;
        step();
        step();
        quiet();
        s_dok = 1'b1; s_rdata = 32'h1111_1111; step();
        s_dok = 1'b1; s_rdata = 32'h2222_2222; step();
        s_dok = 1'b0;

        // inst locked for 3 cycles while data arrives
        new_inst(); s_aok = 1'b0;
        step();
        new_data(1'b1);
        step();
        step();
        s_aok = 1'b1;
        step();
        step();
        drain();

        // full FIFO blocks the third load until one response pops
        new_data(1'b0); s_aok = 1'b1; step();
        new_data(1'b0); step();
        new_data(1'b0); step();
        s_dok = 1'b1; s_rdata = $urandom; step();
        s_dok = 1'b0; step();
        drain();

        // push and pop together at count 1
        new_inst(); s_aok = 1'b1; step();
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) new_data(1'b0);
            else            new_inst();
            s_aok = 1'b1; s_dok = 1'b1; s_rdata = $urandom;
            step();
        end
        drain();

        // spurious responses with nothing outstanding
        quiet(); s_dok = 1'b1; step(); step();
        s_dok = 1'b0;
        new_inst(); s_aok = 1'b1; step();
        drain();

        // reset discards two outstanding data owners
        new_data(1'b0); s_aok = 1'b1; step();
        new_data(1'b1); step();
        quiet(); r_rst = 1'b1; step();
        r_rst = 1'b0;
        new_inst(); s_aok = 1'b1; step();
        drain();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            r_rst = ($urandom_range(0, 299) == 0);
            if (!i_req && $urandom_range(0, 2) == 0) new_inst();
            if (!d_req && $urandom_range(0, 2) == 0) new_data(1'($urandom));
            s_aok   = ($urandom_range(0, 3) != 0);
            s_dok   = (sb_q.size() > 0) ? ($urandom_range(0, 1) == 1)
                                        : ($urandom_range(0, 15) == 0);
            s_rdata = $urandom;
            step();
        end
        r_rst = 1'b0;
        for (int k = 0; k < 10 && (i_req || d_req); k++) begin
            s_aok = 1'b1; s_dok = 1'b0; step();
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
